// File: rtl/sound_cmd_mailbox_if.sv
// Signal bundle between the main-CPU sound latch decode, the Z80 bus and the
// sound command mailbox.
`timescale 1ns/1ps
interface sound_cmd_mailbox_if #(
    parameter int DEPTH_LOG2 = 2
);
  logic                cen_wr;
  logic                cpu_wr;
  logic [7:0]          cpu_din;
  logic                cen_snd;
  logic                snd_rd;
  logic                snd_m1_n;
  logic                snd_iorq_n;
  logic [7:0]          snd_dout;
  logic                snd_int_n;
  logic [DEPTH_LOG2:0] fifo_level;
  logic                overflow;

  modport master (
    output cen_wr, cpu_wr, cpu_din, cen_snd, snd_rd, snd_m1_n, snd_iorq_n,
    input  snd_dout, snd_int_n, fifo_level, overflow
  );

  modport slave (
    input  cen_wr, cpu_wr, cpu_din, cen_snd, snd_rd, snd_m1_n, snd_iorq_n,
    output snd_dout, snd_int_n, fifo_level, overflow
  );
endinterface

// File: rtl/sound_cmd_mailbox.sv
// Main CPU -> Z80 sound command FIFO with Z80 interrupt sequencing
// (assert, acknowledge, wait for the data read, re-arm).
`timescale 1ns/1ps
module sound_cmd_mailbox #(
    parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk_49m,
  input  logic                 reset,
  sound_cmd_mailbox_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_POP} irq_state_t;

  logic [7:0]            mem_reg [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         level_reg, level_next;
  logic [7:0]            hold_reg;
  logic                  overflow_reg, wr_q_reg, rd_q_reg, snd_int_n_reg;
  irq_state_t            state_reg, state_next;

  logic push, pop, push_ok, ack, pending;

  assign push    = bus.cen_wr & bus.cpu_wr & ~wr_q_reg;
  // Pop on the trailing edge of the Z80 read so the byte is stable all access long.
  assign pop     = bus.cen_snd & rd_q_reg & ~bus.snd_rd & (level_reg != '0);
  assign push_ok = push & ((level_reg != FULL) | pop);
  assign ack     = ~bus.snd_m1_n & ~bus.snd_iorq_n;
  assign level_next = level_reg + {{(LW-1){1'b0}}, push_ok} - {{(LW-1){1'b0}}, pop};
  // Entries that were queued before this edge and survive this edge's pop.
  assign pending = level_reg > {{(LW-1){1'b0}}, pop};

  always_ff @(posedge clk_49m) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= bus.cpu_din;
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      hold_reg      <= 8'h00;
      overflow_reg  <= 1'b0;
      wr_q_reg      <= 1'b0;
      rd_q_reg      <= 1'b0;
      snd_int_n_reg <= 1'b1;
      state_reg     <= IDLE;
    end else begin
      if (bus.cen_wr) begin
        wr_q_reg <= bus.cpu_wr;
      end
      if (bus.cen_snd) begin
        rd_q_reg <= bus.snd_rd;
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      end
      if (pop) begin
        hold_reg   <= mem_reg[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
      if (push && !push_ok) begin
        overflow_reg <= 1'b1;
      end
      level_reg     <= level_next;
      state_reg     <= state_next;
      snd_int_n_reg <= (state_next != ASSERT);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cen_snd && pending) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        // Acknowledge outranks a coincident polling read.
        if (ack) begin
          state_next = WAIT_POP;
        end else if (pop && level_next == '0) begin
          state_next = IDLE;
        end
      end
      WAIT_POP: begin
        if (pop) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.snd_dout   = (level_reg != '0) ? mem_reg[rd_ptr_reg] : hold_reg;
  assign bus.snd_int_n  = snd_int_n_reg;
  assign bus.fifo_level = level_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_sound_cmd_mailbox.sv
// Bench for sound_cmd_mailbox: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_sound_cmd_mailbox;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic       clk_49m = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] cnt     = 4'd0;
  int         errors  = 0;
  int         checks  = 0;

  sound_cmd_mailbox_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  sound_cmd_mailbox #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk_49m (clk_49m),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_49m = ~clk_49m;
  always @(posedge clk_49m) cnt <= cnt + 4'd1;
  // Every cen_wr coincides with a cen_snd so push and pop can land together.
  assign bus.cen_wr  = (cnt == 4'd0);
  assign bus.cen_snd = (cnt[1:0] == 2'd0);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ASSERT = 1, M_WAIT = 2;
  logic [7:0] q[$];
  logic [7:0] m_hold;
  logic       m_over, m_wrq, m_rdq, m_int_n;
  int         m_mode;

  always @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_hold = 8'h00; m_over = 1'b0; m_wrq = 1'b0; m_rdq = 1'b0;
      m_int_n = 1'b1; m_mode = M_IDLE;
    end else begin
      int  n_before;
      bit  do_push, do_pop, do_ack;
      n_before = q.size();
      do_push  = bus.cen_wr && bus.cpu_wr && !m_wrq;
      do_pop   = bus.cen_snd && m_rdq && !bus.snd_rd && (n_before > 0);
      do_ack   = !bus.snd_m1_n && !bus.snd_iorq_n;
      if (do_pop) m_hold = q.pop_front();
      if (do_push) begin
        if (q.size() < DEPTH) q.push_back(bus.cpu_din);
        else m_over = 1'b1;
      end
      case (m_mode)
        M_IDLE:   if (bus.cen_snd && (n_before - (do_pop ? 1 : 0)) > 0) m_mode = M_ASSERT;
        M_ASSERT: if (do_ack) m_mode = M_WAIT;
                  else if (do_pop && q.size() == 0) m_mode = M_IDLE;
        default:  if (do_pop) m_mode = M_IDLE;
      endcase
      m_int_n = (m_mode != M_ASSERT);
      if (bus.cen_wr)  m_wrq = bus.cpu_wr;
      if (bus.cen_snd) m_rdq = bus.snd_rd;
    end
  end

  always @(negedge clk_49m) begin
    if (reset) begin
      chk("cyc_dout",  int'(bus.snd_dout),   (q.size() > 0) ? int'(q[0]) : int'(m_hold));
      chk("cyc_level", int'(bus.fifo_level), q.size());
      chk("cyc_ovf",   int'(bus.overflow),   int'(m_over));
      chk("cyc_int_n", int'(bus.snd_int_n),  int'(m_int_n));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_49m);
    #1;
  endtask

  task automatic wait_phase0();
    do begin
      @(posedge clk_49m); #1;
    end while (cnt != 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_49m); #2;
    reset = 1'b0;
    cyc(3); #2;
    reset = 1'b1;
    cyc(2);
  endtask

  task automatic write_cmd(input logic [7:0] d, input int periods);
    bus.cpu_din = d;
    bus.cpu_wr  = 1'b1;
    cyc(16 * periods);
    bus.cpu_wr  = 1'b0;
    cyc(16);
  endtask

  task automatic z80_read(output logic [7:0] d);
    bus.snd_rd = 1'b1;
    cyc(8);
    d = bus.snd_dout;
    bus.snd_rd = 1'b0;
    cyc(8);
  endtask

  task automatic z80_ack();
    int n = 0;
    while (bus.snd_int_n !== 1'b0 && n < 200) begin
      cyc(1); n++;
    end
    chk("ack_wait_int", int'(n < 200), 1);
    bus.snd_m1_n = 1'b0; bus.snd_iorq_n = 1'b0;
    cyc(2);
    bus.snd_m1_n = 1'b1; bus.snd_iorq_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bus.cpu_wr = 1'b0; bus.cpu_din = 8'h00; bus.snd_rd = 1'b0;
    bus.snd_m1_n = 1'b1; bus.snd_iorq_n = 1'b1;
    cyc(5); #2;
    reset = 1'b1;
    cyc(4);
    $display("txn reset release");
    chk("rst_int_n", int'(bus.snd_int_n), 1);
    chk("rst_level", int'(bus.fifo_level), 0);
    chk("rst_ovf",   int'(bus.overflow), 0);
    chk("rst_dout",  int'(bus.snd_dout), 8'h00);

    // Single write held for three cen_wr periods, ack, read.
    $display("txn write 8'h3c held 3 periods");
    write_cmd(8'h3C, 3);
    chk("w3c_level", int'(bus.fifo_level), 1);
    chk("w3c_int_n", int'(bus.snd_int_n), 0);
    z80_ack();
    chk("w3c_ack_int_n", int'(bus.snd_int_n), 1);
    z80_read(d);
    $display("txn read 8'h%02h", d);
    chk("w3c_read", int'(d), 8'h3C);
    chk("w3c_level_after", int'(bus.fifo_level), 0);
    chk("w3c_hold", int'(bus.snd_dout), 8'h3C);
    chk("w3c_int_after", int'(bus.snd_int_n), 1);

    // Polling without acknowledge.
    $display("txn write 8'ha5, polled read");
    write_cmd(8'hA5, 1);
    z80_read(d);
    chk("poll_read", int'(d), 8'hA5);
    chk("poll_int_n", int'(bus.snd_int_n), 1);
    z80_read(d);
    chk("poll_empty_dout", int'(d), 8'hA5);
    chk("poll_empty_level", int'(bus.fifo_level), 0);

    // Overflow: five writes into a four-deep FIFO.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      $display("txn write 8'h%02h", i);
      write_cmd(8'(i), 1);
    end
    chk("ovf_level", int'(bus.fifo_level), 4);
    chk("ovf_flag",  int'(bus.overflow), 1);
    chk("ovf_head",  int'(bus.snd_dout), 8'h01);
    for (int i = 1; i <= 4; i++) begin
      z80_ack();
      z80_read(d);
      $display("txn ack+read 8'h%02h", d);
      chk("ovf_read", int'(d), i);
    end
    chk("ovf_sticky", int'(bus.overflow), 1);

    // Full FIFO with push and pop on the same edge.
    do_reset();
    for (int i = 0; i < 4; i++) write_cmd(8'h10 + 8'(i), 1);
    bus.snd_rd = 1'b1;
    cyc(8);
    wait_phase0();
    bus.cpu_din = 8'h14; bus.cpu_wr = 1'b1; bus.snd_rd = 1'b0;
    cyc(1);
    $display("txn simultaneous push 8'h14 / pop at full");
    chk("sim_level", int'(bus.fifo_level), 4);
    chk("sim_ovf",   int'(bus.overflow), 0);
    chk("sim_head",  int'(bus.snd_dout), 8'h11);
    cyc(20);
    bus.cpu_wr = 1'b0;
    cyc(16);
    for (int i = 1; i <= 4; i++) begin
      z80_read(d);
      chk("sim_read", int'(d), 8'h10 + i);
    end

    // Asynchronous reset while interrupting with three entries queued.
    for (int i = 0; i < 3; i++) write_cmd(8'h21 + 8'(i), 1);
    chk("ar_pre_int_n", int'(bus.snd_int_n), 0);
    chk("ar_pre_level", int'(bus.fifo_level), 3);
    @(negedge clk_49m); #2;
    reset = 1'b0;
    #1;
    $display("txn async reset pulse");
    chk("ar_int_n", int'(bus.snd_int_n), 1);
    chk("ar_level", int'(bus.fifo_level), 0);
    chk("ar_ovf",   int'(bus.overflow), 0);
    cyc(3); #2;
    reset = 1'b1;
    cyc(2);
    write_cmd(8'h77, 1);
    chk("ar_next_level", int'(bus.fifo_level), 1);
    chk("ar_next_dout",  int'(bus.snd_dout), 8'h77);
    chk("ar_next_int_n", int'(bus.snd_int_n), 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 250; t++) begin
      int op = $urandom_range(0, 20);
      if (op < 7) begin
        logic [7:0] b = 8'($urandom);
        int p = $urandom_range(1, 3);
        $display("txn rnd %0d write 8'h%02h for %0d periods", t, b, p);
        bus.cpu_din = b; bus.cpu_wr = 1'b1;
        cyc(16 * p - $urandom_range(0, 10));
        bus.cpu_wr = 1'b0;
        cyc($urandom_range(1, 20));
      end else if (op < 14) begin
        int h = $urandom_range(1, 12);
        $display("txn rnd %0d read high for %0d cycles", t, h);
        bus.snd_rd = 1'b1;
        cyc(h);
        bus.snd_rd = 1'b0;
        cyc($urandom_range(1, 8));
      end else if (op < 19) begin
        int h = $urandom_range(1, 3);
        $display("txn rnd %0d ack for %0d cycles", t, h);
        bus.snd_m1_n = 1'b0; bus.snd_iorq_n = 1'b0;
        cyc(h);
        bus.snd_m1_n = 1'b1; bus.snd_iorq_n = 1'b1;
        cyc($urandom_range(1, 6));
      end else if (op < 20) begin
        $display("txn rnd %0d idle", t);
        cyc($urandom_range(1, 30));
      end else begin
        $display("txn rnd %0d async reset", t);
        bus.cpu_wr = 1'b0; bus.snd_rd = 1'b0;
        do_reset();
      end
    end
    cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sound_cmd_mailbox.md
Name: sound_cmd_mailbox

Overview:
- Command mailbox between the MC6809E main CPU and the Z80 sound CPU.
- Replaces the single sound latch and IRQ-trigger pair with a small FIFO, so back-to-back sound commands are not lost.
- Sequences the Z80 interrupt: assert, acknowledge, wait for the data read, re-arm.
- Sits between the main-CPU I/O decode (sound latch select) and the Z80 data-input multiplexer and INT_n pin.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth (depth = 4 entries); legal range 1..4

Ports:
clk_49m  in  1  system clock, 49.152MHz
reset  in  1  asynchronous, active-low reset
cen_wr  in  1  main-CPU-side clock enable (3.072MHz)
cpu_wr  in  1  main CPU sound-latch write select, level, held for the whole access
cpu_din  in  8  main CPU write data
cen_snd  in  1  Z80 clock enable
snd_rd  in  1  Z80 read of the sound-data address, level (decode_en & region 2'b10 & ~RD_n)
snd_m1_n  in  1  Z80 M1_n
snd_iorq_n  in  1  Z80 IORQ_n
snd_dout  out  8  command byte presented to the Z80
snd_int_n  out  1  Z80 INT_n, active-low, registered
fifo_level  out  DEPTH_LOG2+1  number of queued commands
overflow  out  1  sticky flag: a push was dropped because the FIFO was full

Behaviour:
Reset (asynchronous, reset=0):
- Pointers and level go to 0; overflow=0; snd_int_n=1; hold register=8'h00; state IDLE; edge registers wr_q and rd_q cleared.
- Reset asserted mid-operation discards all queued commands immediately.

Push (main CPU side):
- wr_q samples cpu_wr only on cen_wr cycles.
- A push commits on the clk_49m edge where cen_wr=1, cpu_wr=1 and wr_q=0. One push per access, however long cpu_wr is held.
- cpu_din is written at the tail; fifo_level increments on the next cycle.
- If level=DEPTH the push is dropped, FIFO contents are unchanged and overflow sets to 1. overflow stays 1 until reset.

Pop (Z80 side):
- rd_q samples snd_rd only on cen_snd cycles.
- A pop commits on the edge where cen_snd=1, rd_q=1, snd_rd=0 and level>0. This is the trailing edge, so data stays stable for the whole read access.
- At pop the head byte is copied into the hold register and the read pointer advances.
- A pop while level=0 does nothing.

Output data:
- snd_dout is combinational: the head entry when level>0, otherwise the hold register (last popped byte).

Simultaneous push and pop in the same cycle:
- Both take effect; level is unchanged.
- At level=DEPTH the pop frees the slot first, so the push is accepted and overflow is not set.

Pointer arithmetic:
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
- level is a separate up/down counter, 0..DEPTH.

Interrupt FSM (states IDLE, ASSERT, WAIT_POP):
- IDLE: on a cen_snd cycle with level>0 (post-update), go to ASSERT; snd_int_n=0 from the next cycle.
- ASSERT: snd_int_n=0.
  - An acknowledge (snd_m1_n=0 and snd_iorq_n=0, sampled every clk, not gated by cen) goes to WAIT_POP with snd_int_n=1 from the next cycle.
  - A pop without an acknowledge (polling) leaves the state at ASSERT if level after the pop is >0, else goes to IDLE with snd_int_n=1.
- WAIT_POP: snd_int_n=1. A pop goes to IDLE. Further acknowledges are ignored.
- Re-arm: if commands remain after returning to IDLE, INT reasserts on the next cen_snd. This gives at least one cen_snd period with INT deasserted between commands.
- Acknowledge and pop in the same cycle while in ASSERT: the acknowledge wins, state goes to WAIT_POP, and the pop is still applied to the FIFO.

Latency:
- From the push edge to snd_int_n falling: the first cen_snd at or after the cycle following the push, plus one clk.

Test Plan:
- Reset release, no activity -> snd_int_n=1, fifo_level=0, overflow=0, snd_dout=8'h00.
- Single write 8'h3C, held for 3 cen_wr periods -> exactly one push, fifo_level=1, snd_int_n=0 within one cen_snd period. Acknowledge cycle -> snd_int_n=1. Z80 read of 8'h3C, then snd_rd falls -> fifo_level=0, snd_dout holds 8'h3C, snd_int_n stays 1.
- Writes 8'h01..8'h05 with no reads, DEPTH_LOG2=2 -> fifo_level=4, overflow=1, 8'h05 dropped. Four acknowledge+read sequences return 8'h01,8'h02,8'h03,8'h04 in order, each with INT deasserted for at least one cen_snd between them.
- FIFO full (level=4) with push and pop committing in the same clk -> level stays 4, overflow stays 0, new byte appears as the last entry.
- Polling without an acknowledge: push 8'hA5, Z80 reads and snd_rd falls -> snd_int_n returns to 1 and the state is IDLE. Read with FIFO empty -> snd_dout=8'hA5, level stays 0.
- Async reset pulse while in ASSERT with 3 entries queued -> snd_int_n=1 and fifo_level=0 immediately without a clock edge; overflow=0; the next write behaves as the first after power-up.
